// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word and sends it one bit
// per clock, MSB- or LSB-first, with a one-cycle done pulse after the last bit.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // abort outranks a pending load while idle
        if (load_valid && !abort) begin
          shreg_nxt = din;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          shreg_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (MSB_FIRST) shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          else           shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only state and registers, so no input reaches an output.
  assign busy       = (state == SHIFT);
  assign load_ready = (state == IDLE);
  assign sout_valid = busy;
  assign sout       = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule
